// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, address generation, load/store passthrough
// and a multi-cycle restoring divider that stalls the pipeline until its result is ready.
module ex_stage #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int DIV_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        ex_aluop,
   input  logic [2:0]        ex_alusel,
   input  logic [DATA_W-1:0] ex_rdata1,
   input  logic [DATA_W-1:0] ex_rdata2,
   input  logic [ADDR_W-1:0] ex_waddr,
   input  logic              ex_we,
   input  logic [DATA_W-1:0] ex_laddr,
   input  logic              ex_mre,
   input  logic              ex_mwe,
   input  logic [DATA_W-1:0] ex_mwdata,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_maddr,
   output logic              mem_mre,
   output logic              mem_mwe,
   output logic [DATA_W-1:0] mem_mwdata,
   output logic              stallreq_ex
);
   localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                          SEL_ARITH = 3'b100, SEL_JUMP = 3'b110, SEL_DIV = 3'b111;
   localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR = 8'h27,
                          OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03,
                          OP_ADD  = 8'h20, OP_ADDU = 8'h21, OP_SUB  = 8'h22, OP_SUBU = 8'h23,
                          OP_SLT  = 8'h2A, OP_SLTU = 8'h2B,
                          OP_DIV  = 8'h1A, OP_DIVU = 8'h1B, OP_REM  = 8'h1C, OP_REMU = 8'h1D;
   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = $clog2(DIV_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_st_e;

   div_st_e           st_q, st_d;
   logic [DATA_W-1:0] dvd_q, dvs_q, quot_q, rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              qneg_q, rneg_q, dz_q;

   logic [DATA_W-1:0] alu_res, abs_a, abs_b, r_next, q_next;
   logic [DATA_W:0]   trial, diff;
   logic [SH_W-1:0]   shamt;
   logic              is_div, div_sgn, fits;

   assign shamt   = ex_rdata2[SH_W-1:0];
   assign is_div  = (ex_alusel == SEL_DIV);
   assign div_sgn = (ex_aluop == OP_DIV) || (ex_aluop == OP_REM);

   always_comb begin
      alu_res = '0;
      case (ex_alusel)
         SEL_LOGIC: case (ex_aluop)
            OP_AND:  alu_res = ex_rdata1 & ex_rdata2;
            OP_OR:   alu_res = ex_rdata1 | ex_rdata2;
            OP_XOR:  alu_res = ex_rdata1 ^ ex_rdata2;
            OP_NOR:  alu_res = ~(ex_rdata1 | ex_rdata2);
            default: alu_res = '0;
         endcase
         SEL_SHIFT: case (ex_aluop)
            OP_SLL:  alu_res = ex_rdata1 << shamt;
            OP_SRL:  alu_res = ex_rdata1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(ex_rdata1) >>> shamt);
            default: alu_res = '0;
         endcase
         SEL_ARITH: case (ex_aluop)
            OP_ADD, OP_ADDU: alu_res = ex_rdata1 + ex_rdata2;
            OP_SUB, OP_SUBU: alu_res = ex_rdata1 - ex_rdata2;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(ex_rdata1) < $signed(ex_rdata2)};
            OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, ex_rdata1 < ex_rdata2};
            default: alu_res = '0;
         endcase
         SEL_JUMP: alu_res = ex_laddr;
         default:  alu_res = '0;
      endcase
   end

   // Divider works on magnitudes; signs are reapplied on the final step.
   assign abs_a  = (div_sgn && ex_rdata1[DATA_W-1]) ? -ex_rdata1 : ex_rdata1;
   assign abs_b  = (div_sgn && ex_rdata2[DATA_W-1]) ? -ex_rdata2 : ex_rdata2;
   assign trial  = {rem_q, dvd_q[DATA_W-1]};
   assign diff   = trial - {1'b0, dvs_q};
   assign fits   = (trial >= {1'b0, dvs_q});
   assign r_next = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
   assign q_next = {quot_q[DATA_W-2:0], fits};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= S_IDLE;
      else      st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         S_IDLE:  if (is_div) st_d = S_BUSY;
         S_BUSY:  if (cnt_q == LAST) st_d = S_DONE;
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd_q  <= '0;  dvs_q  <= '0;  quot_q <= '0;  rem_q <= '0;
         cnt_q  <= '0;  qneg_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0;
      end else begin
         case (st_q)
            S_IDLE: if (is_div) begin
               dvd_q  <= abs_a;
               dvs_q  <= abs_b;
               quot_q <= '0;
               rem_q  <= '0;
               cnt_q  <= '0;
               qneg_q <= div_sgn && (ex_rdata1[DATA_W-1] ^ ex_rdata2[DATA_W-1]);
               rneg_q <= div_sgn && ex_rdata1[DATA_W-1];
               dz_q   <= (ex_rdata2 == '0);
            end
            S_BUSY: begin
               dvd_q <= dvd_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  // Divide by zero yields all-ones regardless of operand signs.
                  quot_q <= dz_q ? '1 : (qneg_q ? -q_next : q_next);
                  rem_q  <= rneg_q ? -r_next : r_next;
               end else begin
                  quot_q <= q_next;
                  rem_q  <= r_next;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stallreq_ex = rst && is_div && (st_q != S_DONE);
      mem_waddr   = ex_waddr;
      mem_we      = ex_we;
      mem_wdata   = alu_res;
      mem_maddr   = (ex_mre || ex_mwe) ? ex_rdata1 + ex_rdata2 : '0;
      mem_mre     = ex_mre;
      mem_mwe     = ex_mwe;
      mem_mwdata  = ex_mwdata;
      if (!rst) begin
         mem_waddr  = '0;
         mem_we     = 1'b0;
         mem_wdata  = '0;
         mem_maddr  = '0;
         mem_mre    = 1'b0;
         mem_mwe    = 1'b0;
         mem_mwdata = '0;
      end else if (stallreq_ex) begin
         mem_we    = 1'b0;
         mem_mre   = 1'b0;
         mem_mwe   = 1'b0;
         mem_wdata = '0;
      end else if (is_div) begin
         mem_wdata = (ex_aluop == OP_DIV || ex_aluop == OP_DIVU) ? quot_q : rem_q;
      end
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage, directly downstream of the ID/EX pipeline register; upstream of the EX/MEM register.
- Single-cycle ALU for logic, shift, arithmetic, compare and link operations.
- Iterative radix-2 divider for DIV/DIVU/REM/REMU. It holds the pipeline through the stall controller until the result is ready.
- Also computes the memory address and passes load/store controls through.

Parameters:
- DATA_W, 32, operand/result width; matches REG_BUS.
- ADDR_W, 5, register address width; matches REG_ADDR_BUS.
- DIV_CYCLES, 32, divider iterations; must equal DATA_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- ex_aluop  in  8  operation code (shared ALUOP defines)
- ex_alusel  in  3  result class: NOP/LOGIC/SHIFT/ARITH/JUMP/DIV
- ex_rdata1  in  32  operand A
- ex_rdata2  in  32  operand B (register or immediate)
- ex_waddr  in  5  destination register
- ex_we  in  1  register write enable
- ex_laddr  in  32  link address for jump-and-link
- ex_mre  in  1  memory read enable
- ex_mwe  in  1  memory write enable
- ex_mwdata  in  32  store data
- mem_waddr  out  5  destination register to EX/MEM
- mem_we  out  1  register write enable to EX/MEM
- mem_wdata  out  32  ALU/divider/link result
- mem_maddr  out  32  memory address
- mem_mre  out  1  memory read enable
- mem_mwe  out  1  memory write enable
- mem_mwdata  out  32  store data
- stallreq_ex  out  1  stall request to ctrl (active-high)

Behaviour:
- Reset: asynchronous on rst low.
  - Divider FSM goes to IDLE; dividend, divisor, quotient and remainder registers clear to 0.
  - While rst is low, all outputs are 0: mem_we, mem_mre, mem_mwe and stallreq_ex are disabled.
- Non-divide path, combinational, 0-cycle latency:
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA. Shift amount is ex_rdata2[4:0]; ex_rdata1 is shifted.
  - ARITH: ADD/ADDU/SUB/SUBU are modulo 2^32 with no overflow trap. SLT is signed and SLTU unsigned; both give 32'd1 or 32'd0.
  - JUMP: mem_wdata = ex_laddr.
  - NOP or unknown aluop: mem_wdata = 0.
- Address and passthrough:
  - mem_maddr = ex_rdata1 + ex_rdata2 when ex_mre or ex_mwe is set, else 0.
  - mem_mre, mem_mwe, mem_mwdata, mem_waddr and mem_we pass straight through, except during a divide stall (below).
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when alusel = DIV.
    - Latch |A| and |B| (unsigned ops: raw values) and the result-sign flags.
    - Counter = 0, remainder = 0.
  - BUSY: one restoring shift-subtract step per cycle.
    - After DIV_CYCLES steps, go to DONE and latch the sign-corrected quotient and remainder.
  - DONE -> IDLE unconditionally on the next edge.
- stallreq_ex = (alusel == DIV) && state != DONE. It is high in the IDLE-arrival cycle and all BUSY cycles.
- While stallreq_ex = 1:
  - mem_we, mem_mre and mem_mwe are forced to 0, so a bubble enters EX/MEM.
  - mem_wdata = 0.
- In DONE:
  - mem_wdata = quotient (DIV/DIVU) or remainder (REM/REMU).
  - mem_we = ex_we.
- Latency: the op arrives at edge 0 and the result is valid in the cycle after edge DIV_CYCLES+1. stallreq_ex stays high for DIV_CYCLES+1 cycles.
- Signed rules:
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of the dividend.
  - INT_MIN / -1: quotient 0x80000000, remainder 0.
- Divide by zero, no trap:
  - Quotient 0xFFFFFFFF.
  - Remainder = dividend.
  - Full DIV_CYCLES latency is still taken.
- Operands are held stable by ID/EX during the stall. The divider uses only latched values.
- Reset mid-divide: FSM returns to IDLE and the result is discarded. After reset releases, a divide still present at the input restarts from IDLE.
- Back-to-back divides: DONE -> IDLE, then the next divide starts the following cycle.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, we=1, waddr=3 -> same cycle: mem_wdata=0x80000000, mem_we=1, mem_waddr=3, stallreq_ex=0.
- SRA A=0x80000000, B=0x24 -> mem_wdata=0xF8000000 (shift 4). SLTU A=1, B=0xFFFFFFFF -> mem_wdata=1.
- DIV A=-7, B=2 -> stallreq_ex high for 33 cycles, mem_we=0 throughout. Then quotient 0xFFFFFFFD (-3), mem_we=1; REM gives 0xFFFFFFFF (-1).
- DIVU A=100, B=0 -> after 33 stall cycles mem_wdata=0xFFFFFFFF. REMU A=100, B=0 -> mem_wdata=100.
- rst pulled low 10 cycles into a DIV -> outputs 0 and stallreq_ex=0 immediately. After release with DIV still at the input -> full 33-cycle restart with the correct result.
- Store with A=0x1000, B=0x10, mwe=1, mwdata=0xDEADBEEF -> mem_maddr=0x1010, mem_mwe=1, mem_mwdata=0xDEADBEEF, mem_we=0.
